// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - KGP-RISC instruction fetch stage with single-outstanding memory requests
//
// Purpose: owns the program counter, issues one word request at a time to
// instruction memory, registers the returned word for decode, and honours
// branch/jump redirects from execute by discarding any wrong-path fetch.
//
// Ports:
//   clk, rst_n          core clock, asynchronous active-low reset
//   halt                blocks starting a new request (in-flight one completes)
//   redirect_valid/pc   one-cycle redirect pulse and target (low 2 bits ignored)
//   imem_req/addr       request strobe and address to instruction memory
//   imem_ready/rdata    memory response strobe and data
//   instruction/pc_out  registered instruction word and its address
//   instr_valid/ready   handshake towards decode
//   busy                high whenever the fetch FSM is not idle
module instruction_fetch #(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instruction,
  output logic [ADDR_W-1:0] pc_out,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] addr_q;
  logic              drop;
  logic [ADDR_W-1:0] target;

  assign target    = redirect_pc & ~ADDR_W'(3);
  assign imem_req  = (state == ST_REQ);
  assign imem_addr = addr_q;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      addr_q      <= RESET_PC;
      drop        <= 1'b0;
      instruction <= '0;
      pc_out      <= '0;
      instr_valid <= 1'b0;
    end else if (redirect_valid) begin
      // Redirect wins over everything, including a same-cycle transfer to decode.
      pc          <= target;
      instr_valid <= 1'b0;
      if (state == ST_REQ && !imem_ready) begin
        // The request cannot be withdrawn; remember to throw its data away.
        drop <= 1'b1;
      end else begin
        // Either no request is in flight, or its data is returning right now
        // and is simply not captured.
        drop <= 1'b0;
        if (halt) begin
          state <= ST_IDLE;
        end else begin
          state  <= ST_REQ;
          addr_q <= target;
        end
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (!halt) begin
            state  <= ST_REQ;
            addr_q <= pc;
          end
        end
        ST_REQ: begin
          if (imem_ready) begin
            if (drop) begin
              // Wrong-path data: pc already holds the redirect target.
              drop <= 1'b0;
              if (halt) begin
                state <= ST_IDLE;
              end else begin
                addr_q <= pc;
              end
            end else begin
              instruction <= imem_rdata;
              pc_out      <= addr_q;
              instr_valid <= 1'b1;
              pc          <= pc + ADDR_W'(4);
              state       <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            if (halt) begin
              state <= ST_IDLE;
            end else begin
              state  <= ST_REQ;
              addr_q <= pc;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        halt, redirect_valid, imem_ready, instr_ready;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, instr_valid, busy;
  logic [31:0] imem_addr, instruction, pc_out;

  // Second instance exercising the PC wrap from the top of the address space.
  logic        halt2, redirect_valid2, instr_ready2;
  logic [31:0] redirect_pc2;
  logic        imem_req2, instr_valid2, busy2, imem_ready2;
  logic [31:0] imem_addr2, instruction2, pc_out2, imem_rdata2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instruction_fetch #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .halt(halt),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instruction(instruction), .pc_out(pc_out),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .busy(busy)
  );

  instruction_fetch #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .halt(halt2),
    .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
    .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ready(imem_ready2), .imem_rdata(imem_rdata2),
    .instruction(instruction2), .pc_out(pc_out2),
    .instr_valid(instr_valid2), .instr_ready(instr_ready2), .busy(busy2)
  );

  // Zero-latency memory whose word is the inverted address.
  assign imem_ready2 = imem_req2;
  assign imem_rdata2 = ~imem_addr2;

  logic [31:0] wrap_pc [2];
  logic [31:0] wrap_ins[2];
  int          wrap_n = 0;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && instr_valid2 && wrap_n < 2) begin
      wrap_pc[wrap_n]  <= pc_out2;
      wrap_ins[wrap_n] <= instruction2;
      wrap_n           <= wrap_n + 1;
    end
  end

  typedef struct packed {
    logic        halt;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic [31:0] rdata;
    logic        irdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic h, input logic rv, input logic [31:0] rpc,
                     input logic rdy, input logic [31:0] rdata, input logic irdy,
                     input logic ereq, input logic [31:0] eaddr, input logic evalid,
                     input logic [31:0] einstr, input logic [31:0] epc, input logic ebusy);
    vec_t v;
    v = {h, rv, rpc, rdy, rdata, irdy, ereq, eaddr, evalid, einstr, epc, ebusy};
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".imem_req"},    {31'd0, imem_req},    32'd0);
    chk({tag, ".imem_addr"},   imem_addr,            32'd0);
    chk({tag, ".instruction"}, instruction,          32'd0);
    chk({tag, ".pc_out"},      pc_out,               32'd0);
    chk({tag, ".instr_valid"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, ".busy"},        {31'd0, busy},        32'd0);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_pc;
    logic        prev_wait, prev_stall;
    logic [31:0] prev_addr, prev_instr, prev_pcout;
    int          xfers;

    rst_n = 1'b0;
    halt = 0; redirect_valid = 0; redirect_pc = 0; imem_ready = 0; imem_rdata = 0; instr_ready = 1;
    halt2 = 0; redirect_valid2 = 0; redirect_pc2 = 0; instr_ready2 = 1;

    //   h rv rpc          rdy rdata         ir | req addr         val instr         pc_out       busy
    add(0, 0, 32'h0,       0, 32'h0,         1,   1, 32'h0,       0, 32'h0,        32'h0,       1);
    add(0, 0, 32'h0,       1, 32'h8000_0001, 1,   0, 32'h0,       1, 32'h8000_0001, 32'h0,      1);
    add(0, 0, 32'h0,       0, 32'h0,         1,   1, 32'h4,       0, 32'h8000_0001, 32'h0,      1);
    add(0, 0, 32'h0,       1, 32'h1234_5678, 1,   0, 32'h4,       1, 32'h1234_5678, 32'h4,      1);
    for (int i = 0; i < 5; i++)
      add(0, 0, 32'h0,     0, 32'h0,         0,   0, 32'h4,       1, 32'h1234_5678, 32'h4,      1);
    add(0, 0, 32'h0,       0, 32'h0,         1,   1, 32'h8,       0, 32'h1234_5678, 32'h4,      1);
    add(0, 1, 32'h103,     0, 32'h0,         1,   1, 32'h8,       0, 32'h1234_5678, 32'h4,      1);
    add(0, 0, 32'h0,       0, 32'h0,         1,   1, 32'h8,       0, 32'h1234_5678, 32'h4,      1);
    add(0, 0, 32'h0,       1, 32'hDEAD_BEEF, 1,   1, 32'h100,     0, 32'h1234_5678, 32'h4,      1);
    add(0, 0, 32'h0,       1, 32'h0000_0113, 1,   0, 32'h100,     1, 32'h0000_0113, 32'h100,    1);
    add(0, 1, 32'h200,     0, 32'h0,         1,   1, 32'h200,     0, 32'h0000_0113, 32'h100,    1);
    add(0, 0, 32'h0,       1, 32'hCAFE_0200, 1,   0, 32'h200,     1, 32'hCAFE_0200, 32'h200,    1);
    add(1, 0, 32'h0,       0, 32'h0,         1,   0, 32'h200,     0, 32'hCAFE_0200, 32'h200,    0);
    add(1, 0, 32'h0,       0, 32'h0,         1,   0, 32'h200,     0, 32'hCAFE_0200, 32'h200,    0);
    add(0, 0, 32'h0,       0, 32'h0,         1,   1, 32'h204,     0, 32'hCAFE_0200, 32'h200,    1);
    add(1, 0, 32'h0,       0, 32'h0,         1,   1, 32'h204,     0, 32'hCAFE_0200, 32'h200,    1);
    add(1, 0, 32'h0,       1, 32'h55AA_55AA, 1,   0, 32'h204,     1, 32'h55AA_55AA, 32'h204,    1);
    add(1, 0, 32'h0,       0, 32'h0,         1,   0, 32'h204,     0, 32'h55AA_55AA, 32'h204,    0);
    add(0, 0, 32'h0,       0, 32'h0,         1,   1, 32'h208,     0, 32'h55AA_55AA, 32'h204,    1);

    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      halt           = vecs[i].halt;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      imem_ready     = vecs[i].rdy;
      imem_rdata     = vecs[i].rdata;
      instr_ready    = vecs[i].irdy;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.imem_req", i),    {31'd0, imem_req},    {31'd0, vecs[i].e_req});
      chk($sformatf("v%0d.imem_addr", i),   imem_addr,            vecs[i].e_addr);
      chk($sformatf("v%0d.instr_valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("v%0d.instruction", i), instruction,          vecs[i].e_instr);
      chk($sformatf("v%0d.pc_out", i),      pc_out,               vecs[i].e_pc);
      chk($sformatf("v%0d.busy", i),        {31'd0, busy},        {31'd0, vecs[i].e_busy});
    end

    // Wrap instance: first two delivered words straddle the top of memory.
    chk("wrap.count",  wrap_n,      32'd2);
    chk("wrap.pc0",    wrap_pc[0],  32'hFFFF_FFFC);
    chk("wrap.ins0",   wrap_ins[0], 32'h0000_0003);
    chk("wrap.pc1",    wrap_pc[1],  32'h0000_0000);
    chk("wrap.ins1",   wrap_ins[1], 32'hFFFF_FFFF);

    // Asynchronous reset in the middle of a request, with a response pending.
    halt = 0; redirect_valid = 0; instr_ready = 1;
    imem_ready = 1; imem_rdata = 32'hBAD0_BAD0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("async_rst");
    @(posedge clk);
    #1;
    chk_reset("rst_held");
    imem_ready = 0;
    rst_n = 1'b1;

    // Randomised traffic against an in-order delivery model.
    exp_pc = 32'h0;
    prev_wait = 0; prev_stall = 0;
    prev_addr = 0; prev_instr = 0; prev_pcout = 0;
    xfers = 0;
    for (int n = 0; n < 4000; n++) begin
      if (prev_wait) begin
        chk("rnd.req_held",    {31'd0, imem_req}, 32'd1);
        chk("rnd.addr_stable", imem_addr,         prev_addr);
      end
      if (prev_stall) begin
        chk("rnd.valid_held",  {31'd0, instr_valid}, 32'd1);
        chk("rnd.instr_held",  instruction,          prev_instr);
        chk("rnd.pcout_held",  pc_out,               prev_pcout);
      end
      halt           = ($urandom_range(0, 9) == 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom;
      instr_ready    = ($urandom_range(0, 9) < 7);
      imem_ready     = imem_req && ($urandom_range(0, 2) == 0);
      imem_rdata     = imem_ready ? mem_word(imem_addr) : $urandom;
      if (instr_valid && instr_ready && !redirect_valid) begin
        chk("rnd.pc_out",      pc_out,      exp_pc);
        chk("rnd.instruction", instruction, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        xfers++;
      end
      if (redirect_valid)
        exp_pc = redirect_pc & 32'hFFFF_FFFC;
      prev_wait  = imem_req && !imem_ready;
      prev_addr  = imem_addr;
      prev_stall = instr_valid && !instr_ready && !redirect_valid;
      prev_instr = instruction;
      prev_pcout = pc_out;
      @(posedge clk);
      #1;
    end
    chk("rnd.progress", {31'd0, xfers >= 100}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Front-end stage of the KGP-RISC core; sits directly upstream of instruction_decode.
- Owns the program counter and issues single-outstanding word requests to instruction memory.
- Captures each returned 32-bit word into an output register, with a valid/ready handshake to decode.
- Accepts PC redirects (branch/jump) from execute; any wrong-path fetch already in flight is discarded.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0).
- ADDR_W, 32, PC / instruction-memory address width.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- halt  input  1  when high, no new memory request is started; an in-flight request still completes.
- redirect_valid  input  1  one-cycle pulse; load redirect_pc as the next fetch address.
- redirect_pc  input  ADDR_W  redirect target; bits [1:0] are forced to 0 internally.
- imem_req  output  1  memory request strobe.
- imem_addr  output  ADDR_W  request address; stable while imem_req=1.
- imem_ready  input  1  memory returns data this cycle.
- imem_rdata  input  32  instruction word, valid when imem_ready=1.
- instruction  output  32  registered instruction word to decode.
- pc_out  output  ADDR_W  address of the word in instruction.
- instr_valid  output  1  instruction/pc_out hold a live instruction.
- instr_ready  input  1  decode accepts the instruction this cycle.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; state=IDLE.
  - imem_req=0, imem_addr=RESET_PC.
  - instruction=0, pc_out=0, instr_valid=0, drop=0.
- States:
  - IDLE: no request outstanding. If !halt, go to REQ with imem_req=1 and imem_addr=pc on the next cycle.
  - REQ: imem_req=1 and imem_addr=pc, held constant until imem_ready. A request is never withdrawn.
    - On imem_ready with drop=0: instruction<=imem_rdata, pc_out<=pc, instr_valid<=1, pc<=pc+4, imem_req<=0, go to HOLD.
    - On imem_ready with drop=1: discard the data, clear drop, stay in REQ with the new pc. If halt, go to IDLE instead.
  - HOLD: instr_valid=1; instruction and pc_out stay stable until instr_valid&instr_ready.
    - On transfer with !halt: instr_valid<=0, imem_req<=1, go to REQ. Back-to-back issue, no bubble cycle.
    - On transfer with halt: go to IDLE.
- Latency: imem_ready in cycle N gives instr_valid=1 in cycle N+1. With single-cycle memory, steady throughput is one instruction per 2 cycles.
- PC arithmetic: pc+4 is modulo 2^ADDR_W, so 32'hFFFF_FFFC wraps to 0.
- Redirect (highest priority; checked every cycle):
  - Always: pc<=redirect_pc&~3 and instr_valid<=0. A HOLD instruction presented that cycle is killed even if instr_ready=1.
  - IDLE/HOLD: go to REQ next cycle with imem_addr = new pc (unless halt, then IDLE).
  - REQ without imem_ready: drop<=1; imem_addr stays at the old address until imem_ready.
  - REQ with imem_ready the same cycle: the returned data is discarded; next cycle REQ with the new address.
  - Repeated redirects while drop=1: the last one wins; drop stays 1.
- halt: only blocks starting a new request.
  - HOLD data stays visible until consumed.
  - Deasserting halt in IDLE starts a request the next cycle.
- Mid-operation reset: all state clears immediately. Any memory response arriving while rst_n=0 is ignored.
- instr_valid never rises while drop=1.

Test Plan:
- Reset then release, single-cycle memory returning 0x8000_0001, 0x1234_5678, …, instr_ready=1: imem_addr sequence 0x0, 0x4, 0x8. instruction/pc_out = (0x8000_0001, 0x0) then (0x1234_5678, 0x4). instr_valid pulses every 2nd cycle.
- instr_ready=0 for 5 cycles while in HOLD: instruction and pc_out stay constant, imem_req=0. instr_ready=1 → next request to pc_out+4 issued the cycle after the transfer.
- Memory latency 3 cycles; redirect_valid with redirect_pc=0x0000_0103 in the 1st wait cycle: imem_addr stays at the old value until imem_ready. That data never appears. The next request address is 0x100, and pc_out=0x100 for the next valid.
- Redirect in HOLD with instr_ready=1 the same cycle: instr_valid drops, no transfer counted. The next request address equals the redirect target.
- RESET_PC=32'hFFFF_FFFC: the first fetch is 0xFFFF_FFFC and the second is 0x0000_0000 (wrap).
- halt=1 asserted during REQ: the response is captured and consumed, then the block goes to IDLE with busy=0 and imem_req=0. halt=0 → imem_req=1 next cycle with the following address. rst_n pulsed low mid-REQ → all outputs return to reset values asynchronously.
